pe_core_v2: RTL and testbench

- Single-lane 32-bit integer processing-element core: accepts one operation per cycle (opcode/function plus up to three operands) and returns a 32-bit result with a valid strobe.
- Fixed-latency, fully pipelined, no back-pressure.
- Sits as the compute leaf under the PE array controller; ports connect positionally in the order listed below.

---
 rtl/pe_core_v2.sv | 135 +++++++++++++
 tb/tb_pe_core_v2.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/pe_core_v2.sv
// pe_core_v2 - single-lane 32-bit integer processing-element core.
//
// Accepts one operation per cycle and returns its result through a two-register
// pipeline. There is no back-pressure, and operations leave in issue order.
//
// Ports:
//   clk          rising-edge clock
//   rst_n        asynchronous reset, active-high (rst_n=1 clears the pipeline)
//   opcode_func  [11:5]=opcode, [4:0]=func, [31:12] ignored
//   op1          operand A
//   op2          operand B
//   op3          operand C (accumulate input, used only by MAC)
//   valid_in     operation present this cycle
//   result_out   registered result; holds its value between strobes
//   result_valid one-cycle strobe marking a new result_out
//
// Timing: an op sampled at edge E is executed from the stage-1 registers and
// written to result_out at edge E+1. A consumer that samples at edge E+2 therefore
// sees result_valid=1.

module pe_core_v2 (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] opcode_func,
    input  logic [31:0] op1,
    input  logic [31:0] op2,
    input  logic [31:0] op3,
    input  logic        valid_in,
    output logic [31:0] result_out,
    output logic        result_valid
);

    localparam int DATA_W = 32;

    localparam logic [6:0] OPC_ALU  = 7'h01;

    localparam logic [4:0] FN_ADD   = 5'h01;
    localparam logic [4:0] FN_SUB   = 5'h02;
    localparam logic [4:0] FN_MUL   = 5'h03;
    localparam logic [4:0] FN_AND   = 5'h04;
    localparam logic [4:0] FN_OR    = 5'h05;
    localparam logic [4:0] FN_XOR   = 5'h06;
    localparam logic [4:0] FN_SHL   = 5'h07;
    localparam logic [4:0] FN_SHR   = 5'h08;
    localparam logic [4:0] FN_SRA   = 5'h09;
    localparam logic [4:0] FN_MIN   = 5'h0A;
    localparam logic [4:0] FN_MAX   = 5'h0B;
    localparam logic [4:0] FN_MAC   = 5'h0C;
    localparam logic [4:0] FN_ABS   = 5'h0D;
    localparam logic [4:0] FN_SLT   = 5'h0E;

    // The opcode_func upper bits carry no meaning for this core.
    logic unused_hi;
    assign unused_hi = ^opcode_func[31:12];

    logic [11:0]              opf_p0;
    logic signed [DATA_W-1:0] a_p0;
    logic signed [DATA_W-1:0] b_p0;
    logic signed [DATA_W-1:0] c_p0;
    logic                     vld_p0;
    logic signed [DATA_W-1:0] exe_res;

    // Every operation wraps modulo 2^32. Undefined opcodes and funcs return 0.
    function automatic logic signed [DATA_W-1:0] alu_exec(
        input logic [11:0]              opf,
        input logic signed [DATA_W-1:0] a,
        input logic signed [DATA_W-1:0] b,
        input logic signed [DATA_W-1:0] c
    );
        logic [6:0] opc;
        logic [4:0] fn;
        logic [4:0] sh;
        alu_exec = '0;
        opc      = opf[11:5];
        fn       = opf[4:0];
        sh       = b[4:0];
        if (opc == OPC_ALU) begin
            case (fn)
                FN_ADD:  alu_exec = a + b;
                FN_SUB:  alu_exec = a - b;
                FN_MUL:  alu_exec = a * b;
                FN_AND:  alu_exec = a & b;
                FN_OR:   alu_exec = a | b;
                FN_XOR:  alu_exec = a ^ b;
                FN_SHL:  alu_exec = a << sh;
                FN_SHR:  alu_exec = a >> sh;
                FN_SRA:  alu_exec = a >>> sh;
                FN_MIN:  alu_exec = (a < b) ? a : b;
                FN_MAX:  alu_exec = (a < b) ? b : a;
                FN_MAC:  alu_exec = a * b + c;
                // Negating the most negative value wraps back to itself.
                FN_ABS:  alu_exec = a[DATA_W-1] ? -a : a;
                FN_SLT:  alu_exec = {{(DATA_W-1){1'b0}}, (a < b)};
                default: alu_exec = '0;
            endcase
        end
    endfunction

    // ---- stage 1: capture operation ----
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            vld_p0 <= 1'b0;
            opf_p0 <= '0;
            a_p0   <= '0;
            b_p0   <= '0;
            c_p0   <= '0;
        end else begin
            vld_p0 <= valid_in;
            if (valid_in) begin
                opf_p0 <= opcode_func[11:0];
                a_p0   <= op1;
                b_p0   <= op2;
                c_p0   <= op3;
            end
        end
    end

    always_comb begin
        exe_res = alu_exec(opf_p0, a_p0, b_p0, c_p0);
    end

    // ---- stage 2: execute and register output ----
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            result_valid <= 1'b0;
            result_out   <= '0;
        end else begin
            result_valid <= vld_p0;
            if (vld_p0) begin
                result_out <= exe_res;
            end
        end
    end

endmodule

// File: tb/tb_pe_core_v2.sv
// tb_pe_core_v2 - directed self-checking bench for pe_core_v2.
// Inputs are driven and outputs are sampled on the falling edge. A value read at
// the falling edge before rising edge N is the value visible at edge N.

module tb_pe_core_v2;

    logic        clk;
    logic        rst_n;
    logic [31:0] opcode_func;
    logic [31:0] op1;
    logic [31:0] op2;
    logic [31:0] op3;
    logic        valid_in;
    logic [31:0] result_out;
    logic        result_valid;

    int n_chk;
    int n_bad;

    logic [31:0] s_of  [16];
    logic [31:0] s_a   [16];
    logic [31:0] s_b   [16];
    logic [31:0] s_c   [16];
    logic [31:0] s_exp [16];
    int          s_n;

    pe_core_v2 dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .opcode_func  (opcode_func),
        .op1          (op1),
        .op2          (op2),
        .op3          (op3),
        .valid_in     (valid_in),
        .result_out   (result_out),
        .result_valid (result_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic [31:0] of, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] c, input logic v);
        opcode_func = of;
        op1         = a;
        op2         = b;
        op3         = c;
        valid_in    = v;
    endtask

    task automatic add_op(input logic [31:0] of, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] c, input logic [31:0] exp);
        s_of[s_n]  = of;
        s_a[s_n]   = a;
        s_b[s_n]   = b;
        s_c[s_n]   = c;
        s_exp[s_n] = exp;
        s_n++;
    endtask

    // Issues the queued ops back to back and expects one strobe per op, in order.
    // The inputs are scrambled once each op has been captured.
    task automatic run_stream(input string name);
        for (int k = 0; k < s_n + 2; k++) begin
            @(negedge clk);
            if (k >= 2) begin
                chk($sformatf("%s[%0d].vld", name, k - 2), {31'b0, result_valid}, 32'd1);
                chk($sformatf("%s[%0d].res", name, k - 2), result_out, s_exp[k - 2]);
            end
            if (k < s_n) drive(s_of[k], s_a[k], s_b[k], s_c[k], 1'b1);
            else         drive(32'hDEADBEEF, 32'h12345678, 32'h9ABCDEF0, 32'h0F0F0F0F, 1'b0);
        end
        @(negedge clk);
        chk($sformatf("%s.idle_vld", name), {31'b0, result_valid}, 32'd0);
        chk($sformatf("%s.hold", name), result_out, s_exp[s_n - 1]);
        s_n = 0;
    endtask

    initial begin
        n_chk = 0;
        n_bad = 0;
        s_n   = 0;
        rst_n = 1'b1;
        drive(32'h0, 32'h0, 32'h0, 32'h0, 1'b0);

        // Reset held, then released with no traffic.
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("rst_hold.vld", {31'b0, result_valid}, 32'd0);
            chk("rst_hold.res", result_out, 32'd0);
        end
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("idle.vld", {31'b0, result_valid}, 32'd0);
            chk("idle.res", result_out, 32'd0);
        end

        // Single ADD; checks the latency and that the result holds afterwards.
        drive(32'h021, 32'd10, 32'd20, 32'd0, 1'b1);
        @(negedge clk);
        drive(32'h022, 32'd99, 32'd1, 32'd0, 1'b0);
        chk("add.e1_vld", {31'b0, result_valid}, 32'd0);
        @(negedge clk);
        chk("add.e2_vld", {31'b0, result_valid}, 32'd1);
        chk("add.e2_res", result_out, 32'd30);
        @(negedge clk);
        chk("add.e3_vld", {31'b0, result_valid}, 32'd0);
        chk("add.e3_res", result_out, 32'd30);

        // Back-to-back ops.
        add_op(32'h022, 32'd5,        32'd7,        32'd0, 32'hFFFFFFFE);
        add_op(32'h023, 32'h00010000, 32'h00010000, 32'd0, 32'h00000000);
        add_op(32'h02C, 32'd3,        32'd4,        32'd5, 32'd17);
        add_op(32'h029, 32'h80000000, 32'd4,        32'd0, 32'hF8000000);
        run_stream("b2b");

        // Signed compare ops.
        add_op(32'h02A, 32'hFFFFFFFF, 32'd1, 32'd0, 32'hFFFFFFFF);
        add_op(32'h02B, 32'hFFFFFFFF, 32'd1, 32'd0, 32'd1);
        add_op(32'h02E, 32'hFFFFFFFF, 32'd1, 32'd0, 32'd1);
        add_op(32'h02E, 32'd1, 32'hFFFFFFFF, 32'd0, 32'd0);
        add_op(32'h02A, 32'd3, 32'd9, 32'd0, 32'd3);
        add_op(32'h02B, 32'd3, 32'd9, 32'd0, 32'd9);
        run_stream("cmp");

        // Logic, shifts, ABS edge cases, wraparound, ignored high bits.
        add_op(32'h024, 32'hF0F0F0F0, 32'hFF00FF00, 32'd0, 32'hF000F000);
        add_op(32'h025, 32'hF0F0F0F0, 32'hFF00FF00, 32'd0, 32'hFFF0FFF0);
        add_op(32'h026, 32'hF0F0F0F0, 32'hFF00FF00, 32'd0, 32'h0FF00FF0);
        add_op(32'h027, 32'd1,        32'h0000003F, 32'd0, 32'h80000000);
        add_op(32'h028, 32'h80000000, 32'd4,        32'd0, 32'h08000000);
        add_op(32'h02D, 32'hFFFFFFFB, 32'd0,        32'd0, 32'd5);
        add_op(32'h02D, 32'h80000000, 32'd0,        32'd0, 32'h80000000);
        add_op(32'h02D, 32'd7,        32'd0,        32'd0, 32'd7);
        add_op(32'h021, 32'hFFFFFFFF, 32'd2,        32'd0, 32'd1);
        add_op(32'hFFFFF021, 32'd1,   32'd1,        32'd0, 32'd2);
        add_op(32'h02C, 32'h00010000, 32'h00010000, 32'd7, 32'd7);
        add_op(32'h023, 32'hFFFFFFFF, 32'd3,        32'd0, 32'hFFFFFFFD);
        run_stream("misc");

        // Undefined opcode or func still strobes, with a zero result.
        add_op(32'h021, 32'd4, 32'd4, 32'd0, 32'd8);
        add_op(32'hFE3, 32'd5, 32'd6, 32'd0, 32'd0);
        add_op(32'h021, 32'd4, 32'd5, 32'd0, 32'd9);
        add_op(32'h02F, 32'd5, 32'd6, 32'd0, 32'd0);
        add_op(32'h021, 32'd1, 32'd1, 32'd0, 32'd2);
        add_op(32'h000, 32'd5, 32'd6, 32'd0, 32'd0);
        run_stream("undef");

        // Reset while an ADD is in flight: outputs clear immediately, no strobe later.
        add_op(32'h021, 32'd20, 32'd22, 32'd0, 32'd42);
        run_stream("pre_rst");
        @(negedge clk);
        drive(32'h021, 32'd1, 32'd2, 32'd0, 1'b1);
        @(negedge clk);
        drive(32'h0, 32'h0, 32'h0, 32'h0, 1'b0);
        rst_n = 1'b1;
        #1;
        chk("async_rst.vld", {31'b0, result_valid}, 32'd0);
        chk("async_rst.res", result_out, 32'd0);
        @(negedge clk);
        chk("rst_mid.vld", {31'b0, result_valid}, 32'd0);
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("post_rst.vld", {31'b0, result_valid}, 32'd0);
            chk("post_rst.res", result_out, 32'd0);
        end

        // The pipeline still works after reset.
        add_op(32'h022, 32'd100, 32'd1, 32'd0, 32'd99);
        run_stream("after_rst");

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

    // Safety net in case the stimulus ever stalls.
    initial begin
        #100000;
        $display("FAIL timeout got=%0d exp=%0d", n_chk, 0);
        $fatal(1);
    end

endmodule
